hv_memory_server: RTL and testbench
===================================

Name: hv_memory_server

Overview:
- Responder side of the spatial encoder's SRAM fetch interface.
- Accepts one item address per request and reads three banks in parallel, beat by beat: item memory (IM), projM_neg and projM_pos.
- Assembles each bank's beats into a full HV_DIMENSION-bit hypervector and returns all three together on a ready/valid response channel.
- Sits between the three single-port synchronous SRAM macros and the encoder's IMOut_mod3_D / projM_mod3_neg / projM_mod3_pos inputs.

Parameters:
- HV_DIMENSION, 2048, hypervector width in bits.
- WORD_WIDTH, 64, SRAM read data width per bank; HV_DIMENSION must be an exact multiple.
- ADDR_WIDTH, 8, item address width.
- NUM_BEATS, HV_DIMENSION/WORD_WIDTH (32), words per hypervector; derived, not overridable.
- BEAT_BITS, clog2(NUM_BEATS) (5), derived.

Ports:
- Clk_CI  input  1  clock; all logic on the rising edge.
- Reset_RI  input  1  synchronous, active-high reset.
- ReqValid_SI  input  1  encoder presents a fetch request.
- ReqReady_SO  output  1  server can accept a request.
- ReqAddr_DI  input  ADDR_WIDTH  item address, sampled on the request handshake.
- RspValid_SO  output  1  the three hypervectors are complete and stable.
- RspReady_SI  input  1  encoder consumes the response.
- IMOut_DO  output  [0:HV_DIMENSION-1]  IM hypervector.
- ProjNeg_DO  output  [0:HV_DIMENSION-1]  projM_neg hypervector.
- ProjPos_DO  output  [0:HV_DIMENSION-1]  projM_pos hypervector.
- SramCe_SO  output  1  read enable, shared by all three banks.
- SramAddr_DO  output  ADDR_WIDTH+BEAT_BITS  shared bank address {item_addr, beat}.
- SramIm_DI  input  WORD_WIDTH  IM bank read data.
- SramNeg_DI  input  WORD_WIDTH  projM_neg bank read data.
- SramPos_DI  input  WORD_WIDTH  projM_pos bank read data.
- Busy_SO  output  1  high in any state other than IDLE.

Behaviour:
- FSM states: IDLE, FETCH, DRAIN, RESP.
- Reset (any state): state=IDLE, ReqReady_SO=1, RspValid_SO=0, SramCe_SO=0, SramAddr_DO=0, Busy_SO=0, beat counter=0, all three HV output registers = 0.
- Reset mid-FETCH/DRAIN/RESP: the transaction is abandoned with no response; the next cycle is IDLE.
- IDLE:
  - ReqReady_SO=1.
  - On ReqValid_SI&&ReqReady_SO (cycle 0): latch ReqAddr_DI, beat counter:=0, go to FETCH.
  - ReqReady_SO is low in every other state; there is no request bypass.
- FETCH (cycles 1..NUM_BEATS):
  - SramCe_SO=1, SramAddr_DO={latched_addr, beat}; beat increments each cycle.
  - Leave for DRAIN after issuing beat NUM_BEATS-1.
- SRAM read latency is 1 cycle: data for the beat issued in cycle k is valid in cycle k+1 and captured at the end of cycle k+1.
- Capture mapping: for beat b and bit i, HV[b*WORD_WIDTH+i] = word[WORD_WIDTH-1-i]. The word MSB maps to the lowest HV index (HV bit 0 = MSB of beat 0).
- DRAIN (cycle NUM_BEATS+1): SramCe_SO=0; capture the last beat; go to RESP.
- RESP:
  - RspValid_SO=1 from cycle NUM_BEATS+2 (cycle 34 at defaults).
  - All HV outputs are held stable while RspValid_SO&&!RspReady_SI; backpressure may last indefinitely.
  - On RspValid_SO&&RspReady_SI: RspValid_SO:=0, go to IDLE. ReqReady_SO=1 in the following cycle.
  - Minimum request-to-request spacing is NUM_BEATS+3 cycles.
- HV outputs outside RESP:
  - They keep the previous response until overwritten beat by beat during FETCH/DRAIN.
  - Consumers may only sample them while RspValid_SO=1.
- ReqValid_SI or ReqAddr_DI changing while not in IDLE: ignored.
- SramAddr_DO holds its last value when SramCe_SO=0.
- Beat counter: BEAT_BITS wide, never wraps within a transaction, reset to 0 on accept.
- Busy_SO = (state != IDLE).

Test Plan:
- Reset then idle: hold Reset_RI 2 cycles -> ReqReady_SO=1, RspValid_SO=0, SramCe_SO=0, all HV outputs all-zero. No SramCe_SO pulse for 50 cycles with ReqValid_SI=0.
- Single fetch, addr 0x05:
  - Banks return word = {bank_id[7:0], addr[7:0], 43'b0, beat[4:0]}.
  - Required: SramCe_SO high in exactly cycles 1..32 with addresses 0x0A0..0x0BF, and RspValid_SO rises in cycle 34.
  - IMOut_DO[0:7]=8'h01 and IMOut_DO[64+59:64+63]=5'd1 (bank_id 1 = IM).
- Backpressure: RspReady_SI=0 for 100 cycles after RspValid_SO -> outputs bit-identical every cycle, ReqReady_SO=0. RspReady_SI=1 -> IDLE next cycle.
- Back-to-back: ReqValid_SI held high with addr 0x10 then 0xFF -> second accept exactly 1 cycle after the first response handshake; second response carries addr byte 0xFF in every beat.
- Reset mid-operation: assert Reset_RI in cycle 15 of FETCH -> next cycle IDLE, SramCe_SO=0, RspValid_SO never asserted. A fresh request to 0x22 then completes correctly in 34 cycles.
- Request ignored while busy: pulse ReqValid_SI with addr 0x33 during FETCH of addr 0x44 -> no accept; all issued addresses keep item field 0x44.

Source files
------------

// File: rtl/hv_memory_server_if.sv
// Encoder-side fetch channel of the hypervector memory server: a request
// carrying an item address, and a response carrying three hypervectors.
interface hv_memory_server_if #(
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned HV_DIMENSION = 2048
);
    logic                    ReqValid_SI;
    logic                    ReqReady_SO;
    logic [ADDR_WIDTH-1:0]   ReqAddr_DI;
    logic                    RspValid_SO;
    logic                    RspReady_SI;
    logic [0:HV_DIMENSION-1] IMOut_DO;
    logic [0:HV_DIMENSION-1] ProjNeg_DO;
    logic [0:HV_DIMENSION-1] ProjPos_DO;

    // Encoder side: issues requests, consumes responses
    modport master (
        output ReqValid_SI, ReqAddr_DI, RspReady_SI,
        input  ReqReady_SO, RspValid_SO, IMOut_DO, ProjNeg_DO, ProjPos_DO
    );

    // Server side: accepts requests, produces responses
    modport slave (
        input  ReqValid_SI, ReqAddr_DI, RspReady_SI,
        output ReqReady_SO, RspValid_SO, IMOut_DO, ProjNeg_DO, ProjPos_DO
    );
endinterface

// File: rtl/hv_memory_server.sv
// Hypervector memory server: fetches one item's IM, projM_neg and projM_pos
// hypervectors beat by beat from three SRAM banks and returns them together.
module hv_memory_server #(
    parameter  int unsigned HV_DIMENSION = 2048,
    parameter  int unsigned WORD_WIDTH   = 64,
    parameter  int unsigned ADDR_WIDTH   = 8,
    localparam int unsigned NUM_BEATS    = HV_DIMENSION / WORD_WIDTH,
    localparam int unsigned BEAT_BITS    = $clog2(NUM_BEATS),
    localparam int unsigned SRAM_AW      = ADDR_WIDTH + BEAT_BITS
) (
    input  logic                  Clk_CI,
    input  logic                  Reset_RI,
    hv_memory_server_if.slave     bus,
    output logic                  SramCe_SO,
    output logic [SRAM_AW-1:0]    SramAddr_DO,
    input  logic [WORD_WIDTH-1:0] SramIm_DI,
    input  logic [WORD_WIDTH-1:0] SramNeg_DI,
    input  logic [WORD_WIDTH-1:0] SramPos_DI,
    output logic                  Busy_SO
);

    if (HV_DIMENSION % WORD_WIDTH != 0) begin : g_bad_width
        $error("HV_DIMENSION must be a multiple of WORD_WIDTH");
    end

    localparam logic [BEAT_BITS-1:0] BEAT_LAST = BEAT_BITS'(NUM_BEATS - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, RESP} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   item_q, item_d;
    logic [BEAT_BITS-1:0]    beat_q, beat_d;
    logic                    ce_q, ce_d;
    logic [SRAM_AW-1:0]      saddr_q, saddr_d;
    logic                    req_ready_q, req_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    busy_q, busy_d;
    logic                    cap_en_c;
    logic [BEAT_BITS-1:0]    cap_beat_c;
    logic [0:HV_DIMENSION-1] im_q, neg_q, pos_q;

    // Next-state, registered-output and capture-control decode
    always_comb begin
        state_d     = state_q;
        item_d      = item_q;
        beat_d      = beat_q;
        ce_d        = 1'b0;
        saddr_d     = saddr_q;
        rsp_valid_d = rsp_valid_q;
        cap_en_c    = 1'b0;
        cap_beat_c  = beat_q;
        unique case (state_q)
            IDLE: begin
                if (bus.ReqValid_SI && req_ready_q) begin
                    item_d  = bus.ReqAddr_DI;
                    beat_d  = '0;
                    ce_d    = 1'b1;
                    saddr_d = {bus.ReqAddr_DI, BEAT_BITS'(0)};
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // Read data lags the issued beat by one cycle
                cap_en_c   = (beat_q != '0);
                cap_beat_c = beat_q - 1'b1;
                if (beat_q == BEAT_LAST) begin
                    state_d = DRAIN;
                end else begin
                    beat_d  = beat_q + 1'b1;
                    ce_d    = 1'b1;
                    saddr_d = {item_q, beat_q + 1'b1};
                end
            end
            DRAIN: begin
                cap_en_c    = 1'b1;
                cap_beat_c  = beat_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_valid_q && bus.RspReady_SI) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    // State and control output registers
    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
            state_q     <= IDLE;
            item_q      <= '0;
            beat_q      <= '0;
            ce_q        <= 1'b0;
            saddr_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            item_q      <= item_d;
            beat_q      <= beat_d;
            ce_q        <= ce_d;
            saddr_q     <= saddr_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Beat capture; the ascending HV range puts the word MSB at the lowest index
    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
            im_q  <= '0;
            neg_q <= '0;
            pos_q <= '0;
        end else if (cap_en_c) begin
            im_q[cap_beat_c*WORD_WIDTH +: WORD_WIDTH]  <= SramIm_DI;
            neg_q[cap_beat_c*WORD_WIDTH +: WORD_WIDTH] <= SramNeg_DI;
            pos_q[cap_beat_c*WORD_WIDTH +: WORD_WIDTH] <= SramPos_DI;
        end
    end

    assign bus.ReqReady_SO = req_ready_q;
    assign bus.RspValid_SO = rsp_valid_q;
    assign bus.IMOut_DO    = im_q;
    assign bus.ProjNeg_DO  = neg_q;
    assign bus.ProjPos_DO  = pos_q;
    assign SramCe_SO       = ce_q;
    assign SramAddr_DO     = saddr_q;
    assign Busy_SO         = busy_q;

endmodule

// File: tb/tb_hv_memory_server.sv
// Scoreboard bench for hv_memory_server with behavioural SRAM banks.
module tb_hv_memory_server;
    localparam int unsigned HV  = 2048;
    localparam int unsigned W   = 64;
    localparam int unsigned AW  = 8;
    localparam int unsigned NB  = HV / W;
    localparam int unsigned BB  = 5;
    localparam int unsigned SAW = AW + BB;

    logic           clk = 1'b0;
    logic           rst;
    logic           ce;
    logic [SAW-1:0] saddr;
    logic [W-1:0]   d_im = '0, d_neg = '0, d_pos = '0;
    logic           busy;

    hv_memory_server_if #(.ADDR_WIDTH(AW), .HV_DIMENSION(HV)) bus ();

    hv_memory_server #(.HV_DIMENSION(HV), .WORD_WIDTH(W), .ADDR_WIDTH(AW)) dut (
        .Clk_CI      (clk),
        .Reset_RI    (rst),
        .bus         (bus),
        .SramCe_SO   (ce),
        .SramAddr_DO (saddr),
        .SramIm_DI   (d_im),
        .SramNeg_DI  (d_neg),
        .SramPos_DI  (d_pos),
        .Busy_SO     (busy)
    );

    always #5 clk = ~clk;

    logic [W-1:0] mem_im  [0:(1<<SAW)-1];
    logic [W-1:0] mem_neg [0:(1<<SAW)-1];
    logic [W-1:0] mem_pos [0:(1<<SAW)-1];

    // Single-port synchronous SRAM banks, one cycle read latency
    always @(posedge clk) begin
        if (ce) begin
            d_im  <= mem_im[saddr];
            d_neg <= mem_neg[saddr];
            d_pos <= mem_pos[saddr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_hv(input string nm, input logic [0:HV-1] act, input logic [0:HV-1] exp);
        int idx;
        int b;
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            idx = 0;
            for (int i = 0; i < int'(HV); i++) begin
                if (act[i] !== exp[i]) begin
                    idx = i;
                    break;
                end
            end
            b = idx / int'(W);
            $display("FAIL %s: first bad bit %0d, got beat word %h expected %h (cycle %0d)",
                     nm, idx, act[b*W +: W], exp[b*W +: W], cyc);
        end
    endtask

    task automatic fail(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Reference: HV bit b*W+i is bit W-1-i of the bank word at {item, b}
    function automatic logic [0:HV-1] model_hv(input int bank, input logic [AW-1:0] a);
        logic [0:HV-1]  hv;
        logic [W-1:0]   word;
        logic [SAW-1:0] idx;
        for (int b = 0; b < int'(NB); b++) begin
            idx = {a, BB'(b)};
            case (bank)
                0:       word = mem_im[idx];
                1:       word = mem_neg[idx];
                default: word = mem_pos[idx];
            endcase
            for (int i = 0; i < int'(W); i++) hv[b*W + i] = word[W-1-i];
        end
        return hv;
    endfunction

    logic [0:HV-1] q_im[$], q_neg[$], q_pos[$];

    // Monitor: push on request accept, pop and compare on response handshake
    initial begin
        logic [AW-1:0] exp_item;
        bit            item_live;
        bit            hold;
        logic [0:HV-1] h_im, h_neg, h_pos;
        item_live = 0;
        hold      = 0;
        exp_item  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                q_im.delete();
                q_neg.delete();
                q_pos.delete();
                item_live = 0;
                hold      = 0;
            end else begin
                if (bus.ReqValid_SI && bus.ReqReady_SO) begin
                    q_im.push_back(model_hv(0, bus.ReqAddr_DI));
                    q_neg.push_back(model_hv(1, bus.ReqAddr_DI));
                    q_pos.push_back(model_hv(2, bus.ReqAddr_DI));
                    exp_item  = bus.ReqAddr_DI;
                    item_live = 1;
                end
                if (ce) begin
                    if (!item_live) fail("sram_ce_without_request");
                    else chk("sram_item_field", 64'(saddr[SAW-1:BB]), 64'(exp_item));
                end
                if (bus.RspValid_SO) begin
                    if (hold) begin
                        chk_hv("hold_im", bus.IMOut_DO, h_im);
                        chk_hv("hold_neg", bus.ProjNeg_DO, h_neg);
                        chk_hv("hold_pos", bus.ProjPos_DO, h_pos);
                    end
                    if (bus.RspReady_SI) begin
                        if (q_im.size() == 0) begin
                            fail("response_without_request");
                        end else begin
                            chk_hv("rsp_im", bus.IMOut_DO, q_im.pop_front());
                            chk_hv("rsp_neg", bus.ProjNeg_DO, q_neg.pop_front());
                            chk_hv("rsp_pos", bus.ProjPos_DO, q_pos.pop_front());
                        end
                        item_live = 0;
                        hold      = 0;
                    end else begin
                        hold  = 1;
                        h_im  = bus.IMOut_DO;
                        h_neg = bus.ProjNeg_DO;
                        h_pos = bus.ProjPos_DO;
                    end
                end else begin
                    hold = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns at the negedge of the accept cycle
    task automatic wait_accept(output int t);
        bit ok;
        ok = 0;
        t  = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.ReqValid_SI && bus.ReqReady_SO) begin
                ok = 1;
                t  = cyc;
                break;
            end
            step();
        end
        if (!ok) fail("accept_timeout");
    endtask

    // Returns at the negedge of the first cycle with RspValid_SO high
    task automatic wait_valid(output int t);
        bit ok;
        ok = 0;
        t  = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.RspValid_SO) begin
                ok = 1;
                t  = cyc;
                break;
            end
            step();
        end
        if (!ok) fail("rsp_valid_timeout");
    endtask

    task automatic wait_hs(output int t);
        bit ok;
        ok = 0;
        t  = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.RspValid_SO && bus.RspReady_SI) begin
                ok = 1;
                t  = cyc;
                break;
            end
            step();
        end
        if (!ok) fail("rsp_handshake_timeout");
    endtask

    initial begin
        int            t0, t1, gap;
        logic [0:HV-1] zero_hv;
        logic [0:HV-1] tmp;
        zero_hv          = '0;
        rst              = 1'b1;
        bus.ReqValid_SI  = 1'b0;
        bus.ReqAddr_DI   = '0;
        bus.RspReady_SI  = 1'b0;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < int'(NB); b++) begin
                mem_im[{8'(a), 5'(b)}]  = {8'd1, 8'(a), 43'b0, 5'(b)};
                mem_neg[{8'(a), 5'(b)}] = {8'd2, 8'(a), 43'b0, 5'(b)};
                mem_pos[{8'(a), 5'(b)}] = {8'd3, 8'(a), 43'b0, 5'(b)};
            end
        end

        // Reset state and quiet idle
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 64'(bus.ReqReady_SO), 64'd1);
        chk("rst_rsp_valid", 64'(bus.RspValid_SO), 64'd0);
        chk("rst_sram_ce", 64'(ce), 64'd0);
        chk("rst_sram_addr", 64'(saddr), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk_hv("rst_im", bus.IMOut_DO, zero_hv);
        chk_hv("rst_neg", bus.ProjNeg_DO, zero_hv);
        chk_hv("rst_pos", bus.ProjPos_DO, zero_hv);
        for (int k = 0; k < 50; k++) begin
            step();
            @(negedge clk);
            chk("idle_ce", 64'(ce), 64'd0);
        end

        // Single fetch of item 0x05 with cycle-exact timing
        step();
        bus.ReqValid_SI = 1'b1;
        bus.ReqAddr_DI  = 8'h05;
        @(negedge clk);
        chk("single_accept", 64'(bus.ReqReady_SO), 64'd1);
        step();
        bus.ReqValid_SI = 1'b0;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            chk("single_ce", 64'(ce), (k <= 32) ? 64'd1 : 64'd0);
            if (k <= 32) chk("single_addr", 64'(saddr), 64'({8'h05, 5'(k - 1)}));
            chk("single_rsp_valid", 64'(bus.RspValid_SO), (k == 34) ? 64'd1 : 64'd0);
            chk("single_busy", 64'(busy), 64'd1);
            if (k < 34) step();
        end
        tmp = bus.IMOut_DO;
        chk("im_bank_id_byte", 64'(tmp[0:7]), 64'h01);
        chk("im_beat1_index", 64'(tmp[123:127]), 64'd1);

        // Indefinite backpressure then release
        for (int k = 0; k < 100; k++) begin
            step();
            @(negedge clk);
            chk("bp_req_ready", 64'(bus.ReqReady_SO), 64'd0);
            chk("bp_rsp_valid", 64'(bus.RspValid_SO), 64'd1);
        end
        step();
        bus.RspReady_SI = 1'b1;
        step();
        bus.RspReady_SI = 1'b0;
        @(negedge clk);
        chk("post_rsp_req_ready", 64'(bus.ReqReady_SO), 64'd1);
        chk("post_rsp_busy", 64'(busy), 64'd0);
        chk("post_rsp_valid", 64'(bus.RspValid_SO), 64'd0);

        // Back-to-back requests with ReqValid_SI held high
        step();
        bus.RspReady_SI = 1'b1;
        bus.ReqValid_SI = 1'b1;
        bus.ReqAddr_DI  = 8'h10;
        wait_accept(t0);
        step();
        bus.ReqAddr_DI = 8'hFF;
        wait_hs(t0);
        step();
        wait_accept(t1);
        chk("b2b_accept_gap", 64'(t1 - t0), 64'd1);
        step();
        bus.ReqValid_SI = 1'b0;
        wait_hs(t0);
        tmp = bus.ProjNeg_DO;
        for (int b = 0; b < int'(NB); b += 7) chk("b2b_addr_byte", 64'(tmp[b*W + 8 +: 8]), 64'hFF);

        // Reset in the 15th FETCH cycle abandons the transaction
        step();
        bus.ReqValid_SI = 1'b1;
        bus.ReqAddr_DI  = 8'h60;
        wait_accept(t0);
        step();
        bus.ReqValid_SI = 1'b0;
        repeat (14) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ce", 64'(ce), 64'd0);
        chk("midrst_req_ready", 64'(bus.ReqReady_SO), 64'd1);
        chk("midrst_busy", 64'(busy), 64'd0);
        for (int k = 0; k < 40; k++) begin
            step();
            @(negedge clk);
            chk("midrst_no_rsp", 64'(bus.RspValid_SO), 64'd0);
        end
        step();
        bus.ReqValid_SI = 1'b1;
        bus.ReqAddr_DI  = 8'h22;
        wait_accept(t0);
        step();
        bus.ReqValid_SI = 1'b0;
        wait_valid(t1);
        chk("fresh_latency", 64'(t1 - t0), 64'd34);

        // Request pulse during FETCH is ignored
        step();
        bus.ReqValid_SI = 1'b1;
        bus.ReqAddr_DI  = 8'h44;
        wait_accept(t0);
        step();
        bus.ReqValid_SI = 1'b0;
        repeat (4) step();
        bus.ReqValid_SI = 1'b1;
        bus.ReqAddr_DI  = 8'h33;
        @(negedge clk);
        chk("busy_req_ready", 64'(bus.ReqReady_SO), 64'd0);
        step();
        bus.ReqValid_SI = 1'b0;
        bus.ReqAddr_DI  = '0;
        wait_hs(t0);

        // Random contents, addresses and backpressure
        step();
        bus.RspReady_SI = 1'b0;
        for (int i = 0; i < (1 << SAW); i++) begin
            mem_im[i]  = {$urandom, $urandom};
            mem_neg[i] = {$urandom, $urandom};
            mem_pos[i] = {$urandom, $urandom};
        end
        for (int t = 0; t < 20; t++) begin
            step();
            bus.ReqValid_SI = 1'b1;
            bus.ReqAddr_DI  = 8'($urandom_range(0, 255));
            wait_accept(t0);
            step();
            bus.ReqValid_SI = 1'b0;
            bus.ReqAddr_DI  = 8'($urandom);
            wait_valid(t1);
            chk("rand_latency", 64'(t1 - t0), 64'd34);
            repeat ($urandom_range(0, 4)) step();
            step();
            bus.RspReady_SI = 1'b1;
            wait_hs(t0);
            step();
            bus.RspReady_SI = 1'b0;
            repeat ($urandom_range(0, 3)) step();
        end

        repeat (3) step();
        @(negedge clk);
        gap = q_im.size();
        chk("scoreboard_empty", 64'(gap), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
